// File: rtl/life_grid_if.sv
// Control, seed and status bundle for life_grid.
// The master side drives seed and step requests; the slave side is the engine.
interface life_grid_if #(
   parameter int WIDTH = 8,
   parameter int HEIGHT = 8,
   parameter int GEN_W = 16,
   parameter int POP_W = $clog2(WIDTH*HEIGHT+1)
);
   logic                      seed_ena;
   logic                      seed_bit;
   logic                      step_req;
   logic [8:0]                rule_birth;
   logic [8:0]                rule_survive;
   logic [WIDTH*HEIGHT-1:0]   grid;
   logic                      busy;
   logic                      step_done;
   logic [GEN_W-1:0]          generation;
   logic [POP_W-1:0]          population;
   logic                      pop_valid;
   logic                      extinct;
   logic                      stable;

   modport master (
      output seed_ena, seed_bit, step_req, rule_birth, rule_survive,
      input  grid, busy, step_done, generation, population, pop_valid, extinct, stable
   );

   modport slave (
      input  seed_ena, seed_bit, step_req, rule_birth, rule_survive,
      output grid, busy, step_done, generation, population, pop_valid, extinct, stable
   );
endinterface

// File: rtl/life_grid.sv
// Game-of-Life engine: whole-grid single-cycle generation update, then a
// row-serial population count before signalling step_done.
module life_grid #(
   parameter int WIDTH = 8,
   parameter int HEIGHT = 8,
   parameter bit WRAP = 1'b1,
   parameter int GEN_W = 16,
   parameter int POP_W = $clog2(WIDTH*HEIGHT+1)
) (
   input logic        clk,
   input logic        rst,
   life_grid_if.slave lg
);
   localparam int N = WIDTH*HEIGHT;
   localparam int ROW_W = $clog2(HEIGHT);

   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

   state_t             state_q, state_d;
   logic [N-1:0]       grid_q, grid_next;
   logic [GEN_W-1:0]   gen_q;
   logic [POP_W-1:0]   pop_q, acc_q, row_pop;
   logic [ROW_W-1:0]   row_q;
   logic [WIDTH-1:0]   row_bits;
   logic               pop_valid_q, stable_q, step_done_q;
   logic               seed_go, step_go, last_row;

   // Seed has priority over step when both arrive in IDLE.
   assign seed_go  = (state_q == IDLE) && lg.seed_ena;
   assign step_go  = (state_q == IDLE) && lg.step_req && !lg.seed_ena;
   assign last_row = (row_q == ROW_W'(HEIGHT-1));

   function automatic logic cell_at(input logic [N-1:0] g, input int r, input int c);
      int rr;
      int cc;
      logic [N-1:0] sh;
      rr = r;
      cc = c;
      if (WRAP) begin
         if (rr < 0) rr = HEIGHT-1; else if (rr >= HEIGHT) rr = 0;
         if (cc < 0) cc = WIDTH-1;  else if (cc >= WIDTH)  cc = 0;
      end else if (rr < 0 || rr >= HEIGHT || cc < 0 || cc >= WIDTH) begin
         return 1'b0;
      end
      sh = g >> (rr*WIDTH + cc);
      return sh[0];
   endfunction

   for (genvar r = 0; r < HEIGHT; r++) begin : g_row
      for (genvar c = 0; c < WIDTH; c++) begin : g_col
         logic [3:0] n;
         always_comb begin
            n = '0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if (dr != 0 || dc != 0)
                     n = n + {3'b000, cell_at(grid_q, r+dr, c+dc)};
         end
         assign grid_next[r*WIDTH+c] = grid_q[r*WIDTH+c] ? lg.rule_survive[n] : lg.rule_birth[n];
      end
   end

   always_comb begin
      row_bits = WIDTH'(grid_q >> (int'(row_q)*WIDTH));
      row_pop  = POP_W'($countones(row_bits));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (step_go) state_d = COUNT;
         COUNT:   if (last_row) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grid_q      <= '0;
         gen_q       <= '0;
         pop_q       <= '0;
         acc_q       <= '0;
         row_q       <= '0;
         pop_valid_q <= 1'b1;
         stable_q    <= 1'b0;
         step_done_q <= 1'b0;
      end else begin
         step_done_q <= (state_q == COUNT) && last_row;
         if (seed_go) begin
            grid_q      <= {grid_q[N-2:0], lg.seed_bit};
            gen_q       <= '0;
            pop_valid_q <= 1'b0;
            stable_q    <= 1'b0;
         end else if (step_go) begin
            grid_q      <= grid_next;
            gen_q       <= gen_q + 1'b1;
            stable_q    <= (grid_next == grid_q);
            pop_valid_q <= 1'b0;
            row_q       <= '0;
            acc_q       <= '0;
         end else if (state_q == COUNT) begin
            acc_q <= acc_q + row_pop;
            row_q <= row_q + 1'b1;
            if (last_row) begin
               pop_q       <= acc_q + row_pop;
               pop_valid_q <= 1'b1;
            end
         end
      end
   end

   assign lg.grid       = grid_q;
   assign lg.generation = gen_q;
   assign lg.population = pop_q;
   assign lg.pop_valid  = pop_valid_q;
   assign lg.stable     = stable_q;
   assign lg.step_done  = step_done_q;
   assign lg.busy       = (state_q != IDLE);
   assign lg.extinct    = pop_valid_q && (pop_q == '0);
endmodule

// File: tb/tb_life_grid.sv
// Directed bench for life_grid: a 5x5 dead-edge instance and an 8x8 toroidal one.
module tb_life_grid;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   life_grid_if #(.WIDTH(5), .HEIGHT(5)) if5 ();
   life_grid_if #(.WIDTH(8), .HEIGHT(8)) if8 ();

   life_grid #(.WIDTH(5), .HEIGHT(5), .WRAP(1'b0)) u5 (.clk(clk), .rst(rst), .lg(if5));
   life_grid #(.WIDTH(8), .HEIGHT(8), .WRAP(1'b1)) u8 (.clk(clk), .rst(rst), .lg(if8));

   localparam logic [24:0] BLINK_H = 25'h0003800;
   localparam logic [24:0] BLINK_V = 25'h0021080;
   localparam logic [24:0] EDGE_V  = 25'h0008420;
   localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
   localparam logic [63:0] GLIDER  = 64'h0000_0000_0007_0402;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic seed5(input logic [24:0] p);
      logic [24:0] tmp;
      tmp = p;
      for (int k = 0; k < 25; k++) begin
         if5.seed_ena = 1'b1;
         if5.seed_bit = tmp[24];
         tmp = tmp << 1;
         tick;
      end
      if5.seed_ena = 1'b0;
   endtask

   task automatic seed8(input logic [63:0] p);
      logic [63:0] tmp;
      tmp = p;
      for (int k = 0; k < 64; k++) begin
         if8.seed_ena = 1'b1;
         if8.seed_bit = tmp[63];
         tmp = tmp << 1;
         tick;
      end
      if8.seed_ena = 1'b0;
   endtask

   task automatic step5(output int lat);
      if5.step_req = 1'b1;
      tick;
      lat = 1;
      if5.step_req = 1'b0;
      while (!if5.step_done && lat < 40) begin
         tick;
         lat++;
      end
      tick;
   endtask

   task automatic step8(output int lat);
      if8.step_req = 1'b1;
      tick;
      lat = 1;
      if8.step_req = 1'b0;
      while (!if8.step_done && lat < 40) begin
         tick;
         lat++;
      end
      tick;
   endtask

   initial begin
      int lat;
      int found;
      int t;
      int pulses;
      int times [3];

      if5.seed_ena = 1'b0; if5.seed_bit = 1'b0; if5.step_req = 1'b0;
      if5.rule_birth = 9'h008; if5.rule_survive = 9'h00C;
      if8.seed_ena = 1'b0; if8.seed_bit = 1'b0; if8.step_req = 1'b0;
      if8.rule_birth = 9'h008; if8.rule_survive = 9'h00C;
      tick;
      tick;
      chk("rst_grid",      64'(if8.grid), 64'd0);
      chk("rst_gen",       64'(if8.generation), 64'd0);
      chk("rst_pop",       64'(if8.population), 64'd0);
      chk("rst_pop_valid", 64'(if8.pop_valid), 64'd1);
      chk("rst_stable",    64'(if8.stable), 64'd0);
      chk("rst_busy",      64'(if8.busy), 64'd0);
      chk("rst_done",      64'(if8.step_done), 64'd0);
      chk("rst_extinct",   64'(if8.extinct), 64'd1);
      chk("rst_grid5",     64'(if5.grid), 64'd0);
      rst = 1'b0;
      tick;

      // Blinker on the 5x5 dead-edge grid
      seed5(BLINK_H);
      chk("blink_seed_grid", 64'(if5.grid), 64'(BLINK_H));
      chk("blink_seed_pv",   64'(if5.pop_valid), 64'd0);
      step5(lat);
      chk("blink1_lat",    64'(lat), 64'd6);
      chk("blink1_grid",   64'(if5.grid), 64'(BLINK_V));
      chk("blink1_pop",    64'(if5.population), 64'd3);
      chk("blink1_pv",     64'(if5.pop_valid), 64'd1);
      chk("blink1_stable", 64'(if5.stable), 64'd0);
      chk("blink1_gen",    64'(if5.generation), 64'd1);
      step5(lat);
      chk("blink2_grid",   64'(if5.grid), 64'(BLINK_H));
      chk("blink2_gen",    64'(if5.generation), 64'd2);

      // Vertical bar on column 0: the missing left neighbour column stays dead
      seed5(EDGE_V);
      chk("edge_seed_gen", 64'(if5.generation), 64'd0);
      step5(lat);
      chk("edge_grid", 64'(if5.grid), 64'h0000C00);
      chk("edge_pop",  64'(if5.population), 64'd2);

      // Still-life block
      seed8(BLOCK);
      step8(lat);
      chk("block_lat",     64'(lat), 64'd9);
      chk("block_grid",    64'(if8.grid), BLOCK);
      chk("block_stable",  64'(if8.stable), 64'd1);
      chk("block_pop",     64'(if8.population), 64'd4);
      chk("block_extinct", 64'(if8.extinct), 64'd0);

      // Glider returns home after 32 generations on the 8x8 torus
      seed8(GLIDER);
      for (int k = 0; k < 32; k++) begin
         step8(lat);
         chk("glider_pop", 64'(if8.population), 64'd5);
      end
      chk("glider_grid",   64'(if8.grid), GLIDER);
      chk("glider_gen",    64'(if8.generation), 64'd32);
      chk("glider_stable", 64'(if8.stable), 64'd0);

      // Empty rule set kills everything
      if8.rule_birth = 9'h000;
      if8.rule_survive = 9'h000;
      step8(lat);
      chk("kill_lat",     64'(lat), 64'd9);
      chk("kill_grid",    64'(if8.grid), 64'd0);
      chk("kill_pop",     64'(if8.population), 64'd0);
      chk("kill_extinct", 64'(if8.extinct), 64'd1);
      if8.rule_birth = 9'h008;
      if8.rule_survive = 9'h00C;

      // Seed and step together: seed wins, step dropped
      if8.seed_ena = 1'b1;
      if8.seed_bit = 1'b1;
      if8.step_req = 1'b1;
      tick;
      if8.seed_ena = 1'b0;
      if8.step_req = 1'b0;
      chk("both_grid", 64'(if8.grid), 64'd1);
      chk("both_gen",  64'(if8.generation), 64'd0);
      chk("both_busy", 64'(if8.busy), 64'd0);
      tick;
      chk("both_busy2", 64'(if8.busy), 64'd0);

      // Requests during COUNT are ignored
      seed8(BLOCK);
      if8.step_req = 1'b1;
      tick;
      if8.seed_ena = 1'b1;
      if8.seed_bit = 1'b1;
      chk("cnt_busy", 64'(if8.busy), 64'd1);
      repeat (3) tick;
      if8.seed_ena = 1'b0;
      if8.step_req = 1'b0;
      t = 0;
      while (!if8.step_done && t < 40) begin
         tick;
         t++;
      end
      chk("cnt_done_seen", 64'(if8.step_done), 64'd1);
      chk("cnt_grid",      64'(if8.grid), BLOCK);
      chk("cnt_gen",       64'(if8.generation), 64'd1);
      tick;
      chk("cnt_idle", 64'(if8.busy), 64'd0);

      // Held request: one generation per HEIGHT+2 cycles
      times = '{0, 0, 0};
      found = 0;
      t = 0;
      if8.step_req = 1'b1;
      while (found < 3 && t < 60) begin
         tick;
         t++;
         if (if8.step_done) begin
            times[found] = t;
            found++;
         end
      end
      if8.step_req = 1'b0;
      tick;
      tick;
      chk("held_first", 64'(times[0]), 64'd9);
      chk("held_gap1",  64'(times[1] - times[0]), 64'd10);
      chk("held_gap2",  64'(times[2] - times[1]), 64'd10);
      chk("held_gen",   64'(if8.generation), 64'd4);

      // Reset while COUNT is on row 2
      if8.step_req = 1'b1;
      tick;
      if8.step_req = 1'b0;
      tick;
      tick;
      rst = 1'b1;
      #1;
      chk("mid_rst_grid", 64'(if8.grid), 64'd0);
      chk("mid_rst_pop",  64'(if8.population), 64'd0);
      chk("mid_rst_pv",   64'(if8.pop_valid), 64'd1);
      chk("mid_rst_busy", 64'(if8.busy), 64'd0);
      chk("mid_rst_gen",  64'(if8.generation), 64'd0);
      tick;
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         tick;
         if (if8.step_done) pulses++;
      end
      chk("mid_rst_no_done", 64'(pulses), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/life_grid.md
# life_grid

Parametrised Game-of-Life engine holding a WIDTH×HEIGHT array of cells. It has programmable birth/survive rules, selectable toroidal or dead-edge boundaries, a serial seed load, and a single-step request/done handshake. After each generation update it counts the live population row by row and reports generation number, population, extinction and stability. It sits between the seed/control logic and the display scan-out, replacing per-cell instantiation with one configurable block.

## Interface
- WIDTH, 8: columns (≥3)
- HEIGHT, 8: rows (≥3)
- WRAP, 1: 1 = toroidal edges; 0 = cells outside the grid count as dead
- GEN_W, 16: generation counter width
- POP_W, $clog2(WIDTH*HEIGHT+1): population width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- seed_ena  in  1  shift one seed bit into the array this cycle
- seed_bit  in  1  serial seed data
- step_req  in  1  request one generation
- rule_birth  in  9  bit n set: a dead cell with n live neighbours is born
- rule_survive  in  9  bit n set: a live cell with n live neighbours survives
- grid  out  WIDTH*HEIGHT  cell state; index i = row*WIDTH + col
- busy  out  1  step in progress; new requests ignored
- step_done  out  1  one-cycle pulse; the step's results are valid
- generation  out  GEN_W  generations computed since reset/seed
- population  out  POP_W  live-cell count
- pop_valid  out  1  population matches grid
- extinct  out  1  pop_valid && population==0
- stable  out  1  last step left grid unchanged

## Operation
- FSM states: IDLE, COUNT, DONE.
- **Reset values:** state IDLE; grid 0; generation 0; population 0; pop_valid 1; stable 0; busy 0; step_done 0.
- **Seed (IDLE only):**
  - On seed_ena: grid[0] ← seed_bit and grid[i] ← grid[i-1]. After WIDTH*HEIGHT shifts, the first bit sent sits at index WIDTH*HEIGHT-1.
  - Each seed cycle also clears generation to 0, pop_valid to 0 and stable to 0.
- **Step (IDLE, step_req=1, seed_ena=0):**
  - All cells update simultaneously. n = live neighbours (0..8, 4-bit).
  - next = cell ? rule_survive[n] : rule_birth[n]. Rule inputs are sampled at this edge only.
  - WRAP=1: indices wrap modulo WIDTH/HEIGHT. WRAP=0: out-of-range neighbours are 0.
  - generation ← generation+1, wrapping modulo 2^GEN_W.
  - stable ← (next grid == current grid).
  - pop_valid ← 0. Go to COUNT with row=0, acc=0.
- **COUNT:**
  - Each cycle: acc ← acc + popcount(grid row `row`), row ← row+1. Row popcount is combinational over WIDTH bits.
  - On row==HEIGHT-1: population ← final sum, pop_valid ← 1, go to DONE.
- **DONE:** step_done=1 for one cycle, then IDLE.
- busy = (state != IDLE).
- **Simultaneous seed_ena and step_req in IDLE:** seed wins; step_req is dropped, not queued.
- seed_ena and step_req are ignored while busy; grid is frozen during COUNT/DONE.
- Reset mid-step returns immediately to the reset values; no step_done is produced.

## Timing
- step_req sampled at edge E. grid/generation/stable update at E.
- COUNT occupies edges E+1 .. E+HEIGHT. population/pop_valid update at E+HEIGHT.
- step_done is high in the cycle following E+HEIGHT. Latency step_req→step_done = HEIGHT+1 cycles.
- Earliest next accepted step_req: edge E+HEIGHT+2. Max step rate: 1 generation per HEIGHT+2 cycles.
- Seed: 1 bit per cycle; full load takes WIDTH*HEIGHT cycles.
- All outputs are registered except busy and extinct, which decode registered state.

## Test plan
- **Blinker, 5×5, WRAP=0, Conway rules** (birth=9'h008, survive=9'h00C), horizontal at row 2 cols 1-3:
  - step → vertical at col 2 rows 1-3; population=3; stable=0; generation=1.
  - Second step restores the original grid; generation=2.
- **Block 2×2 at the centre of 8×8:** step → grid unchanged; stable=1; population=4; extinct=0.
- **Glider, 8×8, WRAP=1, Conway:** 32 steps → grid equals the initial seed; generation=32; population=5 after every step.
- **Rule override** birth=0, survive=0 on any non-empty seed: one step → grid=0; extinct=1; step_done exactly HEIGHT+1 cycles after step_req.
- **Handshake edges:**
  - step_req and seed_ena together in IDLE → only the shift occurs; generation=0.
  - step_req and seed_ena during COUNT → no effect.
  - step_req held high continuously → steps spaced HEIGHT+2 cycles apart.
- **Reset mid-step:** assert rst in the COUNT cycle where row=2 → grid=0, population=0, pop_valid=1, busy=0, no step_done pulse.
